// File: rtl/wb_regfile_pkg.sv
// Shared constants and types for the write-back register file.
// Optional feature macro: WB_BYPASS_EN (same-cycle write forwarding).
package wb_regfile_pkg;

    localparam int RegWidth  = 32;
    localparam int AddrWidth = 5;
    localparam int RegNum    = 32;

    typedef logic [RegWidth-1:0]  RegisterBus;
    typedef logic [AddrWidth-1:0] RegisterAddressBus;

    localparam RegisterBus        ZeroWord           = '0;
    localparam RegisterAddressBus NOPRegisterAddress = '0;

    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic ReadEnable   = 1'b1;
    localparam logic ReadDisable  = 1'b0;

    // True when an incoming GPR write targets the given read address.
    function automatic logic gpr_hit(
        input logic              we,
        input RegisterAddressBus wa,
        input RegisterAddressBus ra
    );
        return (we == WriteEnable) && (wa == ra) &&
               (wa != NOPRegisterAddress);
    endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// Write-back / read-port bundle of the register file.
// Optional feature macro: WB_BYPASS_EN (affects read timing only).
interface wb_regfile_if
    import wb_regfile_pkg::*;
#(
    parameter int CNT_W = 32
);
    RegisterBus        wb_wdata;
    RegisterAddressBus wb_wd;
    logic              wb_wreg;
    RegisterBus        wb_hi;
    RegisterBus        wb_lo;
    logic              wb_whilo;
    logic              re1;
    logic              re2;
    RegisterAddressBus raddr1;
    RegisterAddressBus raddr2;
    RegisterBus        rdata1;
    RegisterBus        rdata2;
    RegisterBus        hi_o;
    RegisterBus        lo_o;
    logic [CNT_W-1:0]  retire_cnt;

    modport master (
        output wb_wdata, wb_wd, wb_wreg,
        output wb_hi, wb_lo, wb_whilo,
        output re1, re2, raddr1, raddr2,
        input  rdata1, rdata2, hi_o, lo_o, retire_cnt
    );

    modport slave (
        input  wb_wdata, wb_wd, wb_wreg,
        input  wb_hi, wb_lo, wb_whilo,
        input  re1, re2, raddr1, raddr2,
        output rdata1, rdata2, hi_o, lo_o, retire_cnt
    );

endinterface

// File: rtl/hilo_reg.sv
// HI/LO special registers with optional write forwarding.
// Optional feature macro: WB_BYPASS_EN.
module hilo_reg
    import wb_regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we_i,
    input  RegisterBus hi_i,
    input  RegisterBus lo_i,
    output RegisterBus hi_o,
    output RegisterBus lo_o
);

    RegisterBus hi_q, hi_d;
    RegisterBus lo_q, lo_d;

    // HI and LO load together on a write-enabled edge.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (we_i != WriteDisable) begin
            hi_d = hi_i;
            lo_d = lo_i;
        end
    end

    // State register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= ZeroWord;
            lo_q <= ZeroWord;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // Output view; forwarding is held off while reset is active.
    always_comb begin
        hi_o = hi_q;
        lo_o = lo_q;
`ifdef WB_BYPASS_EN
        if (rst && (we_i == WriteEnable)) begin
            hi_o = hi_i;
            lo_o = lo_i;
        end
`endif
    end

endmodule

// File: rtl/wb_regfile.sv
// GPR file with two read ports, HI/LO and a retire counter.
// Optional feature macro: WB_BYPASS_EN (same-cycle write forwarding).
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    wb_regfile_if.slave  bus
);

    RegisterBus       gpr_q [1:RegNum-1];
    logic             gpr_we;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    RegisterBus       rd1, rd2;

    // A write is effective only when enabled and not aimed at r0.
    always_comb begin
        gpr_we = (bus.wb_wreg == WriteEnable) &&
                 (bus.wb_wd != NOPRegisterAddress);
    end

    // GPR storage; r0 has no flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < RegNum; i++) begin
                gpr_q[i] <= ZeroWord;
            end
        end else if (gpr_we) begin
            gpr_q[bus.wb_wd] <= bus.wb_wdata;
        end
    end

    // Retire counter steps on every effective write and wraps silently.
    always_comb begin
        cnt_d = cnt_q;
        if (gpr_we) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Read port 1.
    always_comb begin
        rd1 = ZeroWord;
        if (bus.re1 == ReadDisable) begin
            rd1 = ZeroWord;
        end else if (bus.raddr1 == NOPRegisterAddress) begin
            rd1 = ZeroWord;
`ifdef WB_BYPASS_EN
        end else if (rst && gpr_hit(bus.wb_wreg, bus.wb_wd, bus.raddr1)) begin
            rd1 = bus.wb_wdata;
`endif
        end else begin
            rd1 = gpr_q[bus.raddr1];
        end
    end

    // Read port 2.
    always_comb begin
        rd2 = ZeroWord;
        if (bus.re2 == ReadDisable) begin
            rd2 = ZeroWord;
        end else if (bus.raddr2 == NOPRegisterAddress) begin
            rd2 = ZeroWord;
`ifdef WB_BYPASS_EN
        end else if (rst && gpr_hit(bus.wb_wreg, bus.wb_wd, bus.raddr2)) begin
            rd2 = bus.wb_wdata;
`endif
        end else begin
            rd2 = gpr_q[bus.raddr2];
        end
    end

    assign bus.rdata1     = rd1;
    assign bus.rdata2     = rd2;
    assign bus.retire_cnt = cnt_q;

    hilo_reg u_hilo (
        .clk  (clk),
        .rst  (rst),
        .we_i (bus.wb_whilo),
        .hi_i (bus.wb_hi),
        .lo_i (bus.wb_lo),
        .hi_o (bus.hi_o),
        .lo_o (bus.lo_o)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile (table vectors plus corner sequences).
// Honours WB_BYPASS_EN for same-cycle expectations.
module tb_wb_regfile;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst;

    wb_regfile_if #(.CNT_W(32)) bus  ();
    wb_regfile_if #(.CNT_W(4))  bus4 ();

    wb_regfile #(.CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    wb_regfile #(.CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wreg;
        logic [4:0]  wd;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        re1;
        logic [4:0]  ra1;
        logic        re2;
        logic [4:0]  ra2;
        logic [31:0] e_r1;
        logic [31:0] e_r2;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        logic [31:0] e_cnt;
    } vec_t;

    int n_run;
    int n_fail;
    vec_t vecs [9];
    vec_t exp_q [$];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        bus.wb_wreg  = 1'b0;
        bus.wb_wd    = 5'd0;
        bus.wb_wdata = 32'h0;
        bus.wb_whilo = 1'b0;
        bus.wb_hi    = 32'h0;
        bus.wb_lo    = 32'h0;
        bus.re1      = 1'b0;
        bus.raddr1   = 5'd0;
        bus.re2      = 1'b0;
        bus.raddr2   = 5'd0;
        bus4.wb_wreg  = 1'b0;
        bus4.wb_wd    = 5'd0;
        bus4.wb_wdata = 32'h0;
        bus4.wb_whilo = 1'b0;
        bus4.wb_hi    = 32'h0;
        bus4.wb_lo    = 32'h0;
        bus4.re1      = 1'b0;
        bus4.raddr1   = 5'd0;
        bus4.re2      = 1'b0;
        bus4.raddr2   = 5'd0;
    endtask

    task automatic drive(input vec_t v);
        bus.wb_wreg  = v.wreg;
        bus.wb_wd    = v.wd;
        bus.wb_wdata = v.wdata;
        bus.wb_whilo = v.whilo;
        bus.wb_hi    = v.hi;
        bus.wb_lo    = v.lo;
        bus.re1      = v.re1;
        bus.raddr1   = v.ra1;
        bus.re2      = v.re2;
        bus.raddr2   = v.ra2;
    endtask

    initial begin
        vec_t e;
        n_run  = 0;
        n_fail = 0;
        rst    = 1'b0;
        idle();

        // wreg wd wdata whilo hi lo re1 ra1 re2 ra2 | r1 r2 hi lo cnt
        vecs[0] = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 5, 1, 1,
                    0, 0, 0, 0, 0};
        vecs[1] = '{0, 0, 0, 0, 0, 0, 1, 5, 0, 5,
                    32'hDEADBEEF, 0, 0, 0, 1};
        vecs[2] = '{1, 0, 32'h12345678, 0, 0, 0, 1, 0, 1, 5,
                    0, 32'hDEADBEEF, 0, 0, 1};
        vecs[3] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0,
                    0, 0, 0, 0, 1};
        vecs[4] = '{1, 31, 32'hFFFFFFFF, 1, 1, 2, 1, 5, 1, 5,
                    32'hDEADBEEF, 32'hDEADBEEF,
                    BYP ? 32'h1 : 32'h0, BYP ? 32'h2 : 32'h0, 1};
        vecs[5] = '{1, 1, 32'h11111111, 0, 32'hAAAA, 32'hBBBB,
                    1, 31, 1, 31,
                    32'hFFFFFFFF, 32'hFFFFFFFF, 1, 2, 2};
        vecs[6] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 1,
                    32'h11111111, 0, 1, 2, 3};
        vecs[7] = '{0, 1, 0, 0, 0, 0, 1, 1, 1, 31,
                    32'h11111111, 32'hFFFFFFFF, 1, 2, 3};
        vecs[8] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0,
                    32'h11111111, 0, 1, 2, 3};

        // Reset state, with reads enabled against stored data.
        repeat (2) @(posedge clk);
        #1;
        bus.re1 = 1'b1; bus.raddr1 = 5'd5;
        bus.re2 = 1'b1; bus.raddr2 = 5'd31;
        #1;
        check("rst.r1", bus.rdata1, 32'h0);
        check("rst.r2", bus.rdata2, 32'h0);
        check("rst.hi", bus.hi_o, 32'h0);
        check("rst.lo", bus.lo_o, 32'h0);
        check("rst.cnt", bus.retire_cnt, 32'h0);
        @(negedge clk);
        idle();
        rst = 1'b1;

        // Table vectors through the scoreboard.
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            exp_q.push_back(vecs[i]);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                check($sformatf("v%0d.sb", i), 32'h1, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("v%0d.r1", i), bus.rdata1, e.e_r1);
                check($sformatf("v%0d.r2", i), bus.rdata2, e.e_r2);
                check($sformatf("v%0d.hi", i), bus.hi_o, e.e_hi);
                check($sformatf("v%0d.lo", i), bus.lo_o, e.e_lo);
                check($sformatf("v%0d.cnt", i), bus.retire_cnt, e.e_cnt);
            end
        end

        // Same-cycle write/read of r7.
        @(posedge clk);
        #1;
        idle();
        bus.wb_wreg = 1'b1; bus.wb_wd = 5'd7;
        bus.wb_wdata = 32'hA5A5A5A5;
        bus.re2 = 1'b1; bus.raddr2 = 5'd7;
        @(negedge clk);
        check("byp.r2", bus.rdata2, BYP ? 32'hA5A5A5A5 : 32'h0);
        @(posedge clk);
        #1;
        bus.wb_wreg = 1'b0; bus.wb_wdata = 32'h0;
        @(negedge clk);
        check("byp.r2next", bus.rdata2, 32'hA5A5A5A5);
        check("byp.cnt", bus.retire_cnt, 32'd4);

        // Write r3 and r9, then assert reset mid-cycle.
        @(posedge clk);
        #1;
        idle();
        bus.wb_wreg = 1'b1; bus.wb_wd = 5'd3; bus.wb_wdata = 32'h33;
        @(posedge clk);
        #1;
        bus.wb_wd = 5'd9; bus.wb_wdata = 32'h99;
        @(posedge clk);
        #1;
        idle();
        bus.re1 = 1'b1; bus.raddr1 = 5'd3;
        bus.re2 = 1'b1; bus.raddr2 = 5'd9;
        @(negedge clk);
        check("pre.r1", bus.rdata1, 32'h33);
        check("pre.r2", bus.rdata2, 32'h99);
        check("pre.cnt", bus.retire_cnt, 32'd6);
        #2;
        rst = 1'b0;
        #1;
        check("arst.r1", bus.rdata1, 32'h0);
        check("arst.r2", bus.rdata2, 32'h0);
        check("arst.hi", bus.hi_o, 32'h0);
        check("arst.lo", bus.lo_o, 32'h0);
        check("arst.cnt", bus.retire_cnt, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post.r1", bus.rdata1, 32'h0);

        // Narrow counter wraps after 16 effective writes.
        idle();
        for (int i = 0; i < 17; i++) begin
            bus4.wb_wreg  = 1'b1;
            bus4.wb_wd    = 5'((i % 31) + 1);
            bus4.wb_wdata = 32'(i);
            @(posedge clk);
            #1;
            check($sformatf("wrap%0d", i), {28'h0, bus4.retire_cnt},
                  32'((i + 1) % 16));
        end
        bus4.wb_wd = 5'd0;
        @(posedge clk);
        #1;
        check("wrap.r0", {28'h0, bus4.retire_cnt}, 32'd1);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, giving the width of the write-back retire counter.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, an asynchronous active-low reset.
REQ-004 The block SHALL have port wb_wdata, input, 32, the GPR write data from MEM/WB.
REQ-005 The block SHALL have port wb_wd, input, 5, the GPR write address.
REQ-006 The block SHALL have port wb_wreg, input, 1, the GPR write enable.
REQ-007 The block SHALL have ports wb_hi and wb_lo, input, 32 each, the HI/LO write data.
REQ-008 The block SHALL have port wb_whilo, input, 1, the HI/LO write enable.
REQ-009 The block SHALL have ports re1 and re2, input, 1 each, the read enables.
REQ-010 The block SHALL have ports raddr1 and raddr2, input, 5 each, the read addresses.
REQ-011 The block SHALL have ports rdata1 and rdata2, output, 32 each, the combinational read data.
REQ-012 The block SHALL have ports hi_o and lo_o, output, 32 each, the current HI/LO values.
REQ-013 The block SHALL have port retire_cnt, output, CNT_W, the count of effective GPR writes.

Function
REQ-014 The block SHALL hold 31 storage GPRs, indices 1..31; GPR 0 SHALL NOT be stored.
REQ-015 On a clock edge with wb_wreg=1 and wb_wd!=0, GPR[wb_wd] SHALL take wb_wdata.
REQ-016 A write with wb_wd=0 SHALL be ignored.
REQ-017 On a clock edge with wb_whilo=1, HI SHALL take wb_hi and LO SHALL take wb_lo in the same edge.
REQ-018 Port n SHALL read 0 when ren=0.
REQ-019 Port n SHALL read 0 when raddrn=0, regardless of any write to 0.
REQ-020 Otherwise, port n SHALL read the stored GPR[raddrn], subject to REQ-027.
REQ-021 Both read ports SHALL be independent; identical addresses SHALL return identical data.
REQ-022 retire_cnt SHALL increment by 1 on each edge where an effective GPR write occurs (per REQ-015).
REQ-023 retire_cnt SHALL wrap from all-ones to 0 without flagging.
REQ-024 Read latency SHALL be 0 cycles (combinational); write latency SHALL be 1 edge.

Reset
REQ-025 While rst=0, asynchronously:
- GPR1..31 SHALL be 0.
- HI and LO SHALL be 0.
- retire_cnt SHALL be 0.
- rdata1, rdata2, hi_o and lo_o SHALL follow from the cleared state.
REQ-026 A write presented on the edge coinciding with reset deassertion SHALL be ignored; the first write SHALL take effect on the next edge where rst=1.

Configuration
REQ-027 With macro WB_BYPASS_EN defined, the following SHALL forward the incoming write data in the same cycle:
- a read with re=1, raddr=wb_wd!=0 and wb_wreg=1 SHALL return wb_wdata;
- hi_o/lo_o SHALL show wb_hi/wb_lo while wb_whilo=1.
REQ-028 With WB_BYPASS_EN undefined, all reads SHALL return stored state only, so a write becomes visible one cycle after its edge.
REQ-029 Forwarding SHALL be suppressed while rst=0.

Structure
REQ-030 The shared include SHALL hold the following constants (the block SHALL NOT redefine them locally):
- RegisterBus, RegisterAddressBus, ZeroWord, NOPRegisterAddress;
- WriteEnable/WriteDisable, ReadEnable/ReadDisable;
- register count 32.
REQ-031 HI/LO storage, bypass and outputs SHALL live in one sub-module, hilo_reg, instantiated once.

Verification
REQ-032 A write of 0xDEADBEEF to reg 5, then re1=1 and raddr1=5 on the next cycle, SHALL give rdata1=0xDEADBEEF; retire_cnt SHALL read 1.
REQ-033 A write of 0x12345678 to reg 0 SHALL leave rdata=0 when reading reg 0, and retire_cnt SHALL NOT change.
REQ-034 For a same-cycle write of 0xA5A5A5A5 to reg 7 with raddr2=7:
- WB_BYPASS_EN defined: rdata2=0xA5A5A5A5 that cycle;
- WB_BYPASS_EN undefined: rdata2=old value that cycle, new value next cycle.
REQ-035 wb_whilo=1 with wb_hi=0x1 and wb_lo=0x2, then wb_whilo=0 with other data, SHALL give hi_o=0x1 and lo_o=0x2 held.
REQ-036 With regs 3 and 9 written, asserting rst=0 mid-cycle SHALL make rdata1, rdata2, hi_o, lo_o and retire_cnt 0 immediately, before the next clk edge.
REQ-037 With CNT_W=4, 16 effective writes SHALL return retire_cnt to 0.
